// File: rtl/serial_adder_ctrl_if.sv
// serial_adder_ctrl_if: start/busy/done handshake, operands and results of the serial adder
interface serial_adder_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             op_sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             overflow;
    logic             zero;
    modport master (
        output start, op_sub, a, b,
        input  busy, done, result, cout, overflow, zero
    );
    modport slave (
        input  start, op_sub, a, b,
        output busy, done, result, cout, overflow, zero
    );
endinterface

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial add/subtract, one full_adder stepped LSB-first per clock
module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);
    assign o_s = i_a ^ i_b ^ i_c;
    assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    serial_adder_ctrl_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           r_state, w_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a, r_b, r_result, w_res_next;
    logic             r_carry, r_cout, r_ovf, r_zero;
    logic             w_s, w_co, w_last, w_busy, w_done;

    full_adder u_fa (
        .i_a(r_a[r_cnt]),
        .i_b(r_b[r_cnt]),
        .i_c(r_carry),
        .o_s(w_s),
        .o_c(w_co)
    );

    assign w_last = (r_cnt == LAST);

    always_comb begin
        w_res_next        = r_result;
        w_res_next[r_cnt] = w_s;
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = IDLE;
        case (r_state)
            IDLE:    w_next = bus.start ? RUN : IDLE;
            RUN:     w_next = w_last ? DONE : RUN;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_busy = (r_state == RUN);
        w_done = (r_state == DONE);
    end

    // B is stored pre-inverted and the carry seeded with op_sub, so subtract is a + ~b + 1
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_carry  <= 1'b0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b0;
        end else if (r_state == IDLE && bus.start) begin
            r_a     <= bus.a;
            r_b     <= bus.op_sub ? ~bus.b : bus.b;
            r_carry <= bus.op_sub;
            r_cnt   <= '0;
        end else if (r_state == RUN) begin
            r_result <= w_res_next;
            r_carry  <= w_co;
            if (w_last) begin
                r_cout <= w_co;
                r_ovf  <= r_carry ^ w_co;
                r_zero <= (w_res_next == '0);
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign bus.busy     = w_busy;
    assign bus.done     = w_done;
    assign bus.result   = r_result;
    assign bus.cout     = r_cout;
    assign bus.overflow = r_ovf;
    assign bus.zero     = r_zero;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed checks at WIDTH=8 plus model-checked random ops at WIDTH=2 and 32
module tb_serial_adder_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl_if #(.WIDTH(8))  bus8 ();
    serial_adder_ctrl_if #(.WIDTH(2))  bus2 ();
    serial_adder_ctrl_if #(.WIDTH(32)) bus32 ();

    serial_adder_ctrl #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));
    serial_adder_ctrl #(.WIDTH(2))  dut2  (.clk(clk), .rst(rst), .bus(bus2));
    serial_adder_ctrl #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32));

    function automatic logic [66:0] model(input int w, input logic sub, input logic [63:0] a, input logic [63:0] b);
        logic [63:0] mask, res;
        logic        co, ov;
        int          m;
        mask = (64'd1 << w) - 64'd1;
        m    = w - 1;
        res  = (sub ? a - b : a + b) & mask;
        co   = sub ? (a >= b) : (((a + b) >> w) & 64'd1) != 0;
        ov   = sub ? (a[m] != b[m] && res[m] != a[m]) : (a[m] == b[m] && res[m] != a[m]);
        return {res, co, ov, res == 64'd0};
    endfunction

    task automatic do_op8(input logic sub, input logic [7:0] a, input logic [7:0] b, output int cyc, output int bsy);
        @(negedge clk);
        bus8.start = 1'b1; bus8.op_sub = sub; bus8.a = a; bus8.b = b;
        @(negedge clk);
        bus8.start = 1'b0; bus8.op_sub = ~sub; bus8.a = ~a; bus8.b = b ^ 8'h5A;
        cyc = 1;
        bsy = bus8.busy ? 1 : 0;
        while (!bus8.done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (bus8.busy) bsy++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if (bus8.busy !== 1'b0 || bus8.done !== 1'b0) begin
            fails++; $display("FAIL reset_hs busy=%b done=%b want 0 0", bus8.busy, bus8.done);
        end
        tests++;
        if ({bus8.result, bus8.cout, bus8.overflow, bus8.zero} !== 11'h0) begin
            fails++; $display("FAIL reset_out result=%h c/v/z=%b%b%b want 00 000", bus8.result, bus8.cout, bus8.overflow, bus8.zero);
        end
        tests++;
        if (bus2.busy !== 1'b0 || bus32.busy !== 1'b0 || bus32.result !== 32'h0) begin
            fails++; $display("FAIL reset_other busy2=%b busy32=%b res32=%h want 0 0 0", bus2.busy, bus32.busy, bus32.result);
        end
        rst = 1'b0;
    endtask

    task automatic test_add;
        int cyc, bsy;
        do_op8(1'b0, 8'h5A, 8'h33, cyc, bsy);
        tests++;
        if (cyc !== 9 || bsy !== 8) begin
            fails++; $display("FAIL add_timing done_cycle=%0d busy_cycles=%0d want 9 8", cyc, bsy);
        end
        tests++;
        if ({bus8.result, bus8.cout, bus8.overflow, bus8.zero} !== {8'h8D, 3'b010}) begin
            fails++; $display("FAIL add_5a_33 result=%h c/v/z=%b%b%b want 8d 010", bus8.result, bus8.cout, bus8.overflow, bus8.zero);
        end
        @(negedge clk);
        tests++;
        if (bus8.done !== 1'b0 || bus8.busy !== 1'b0 || bus8.result !== 8'h8D) begin
            fails++; $display("FAIL add_done_pulse done=%b busy=%b result=%h want 0 0 8d", bus8.done, bus8.busy, bus8.result);
        end
        do_op8(1'b0, 8'hFF, 8'h01, cyc, bsy);
        tests++;
        if (cyc !== 9 || {bus8.result, bus8.cout, bus8.overflow, bus8.zero} !== {8'h00, 3'b101}) begin
            fails++; $display("FAIL add_ff_01 cyc=%0d result=%h c/v/z=%b%b%b want 9 00 101", cyc, bus8.result, bus8.cout, bus8.overflow, bus8.zero);
        end
    endtask

    task automatic test_sub;
        int cyc, bsy;
        do_op8(1'b1, 8'h10, 8'h20, cyc, bsy);
        tests++;
        if (cyc !== 9 || {bus8.result, bus8.cout, bus8.overflow, bus8.zero} !== {8'hF0, 3'b000}) begin
            fails++; $display("FAIL sub_10_20 cyc=%0d result=%h c/v/z=%b%b%b want 9 f0 000", cyc, bus8.result, bus8.cout, bus8.overflow, bus8.zero);
        end
        do_op8(1'b1, 8'h80, 8'h01, cyc, bsy);
        tests++;
        if (cyc !== 9 || {bus8.result, bus8.cout, bus8.overflow, bus8.zero} !== {8'h7F, 3'b110}) begin
            fails++; $display("FAIL sub_80_01 cyc=%0d result=%h c/v/z=%b%b%b want 9 7f 110", cyc, bus8.result, bus8.cout, bus8.overflow, bus8.zero);
        end
        do_op8(1'b1, 8'h33, 8'h33, cyc, bsy);
        tests++;
        if (cyc !== 9 || {bus8.result, bus8.cout, bus8.overflow, bus8.zero} !== {8'h00, 3'b101}) begin
            fails++; $display("FAIL sub_33_33 cyc=%0d result=%h c/v/z=%b%b%b want 9 00 101", cyc, bus8.result, bus8.cout, bus8.overflow, bus8.zero);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] res_seen [3];
        int         at_seen  [3];
        logic [7:0] exp_res  [3];
        int         n;
        exp_res = '{8'h03, 8'h53, 8'hA3};
        n = 0;
        for (int i = 0; i <= 30; i++) begin
            @(negedge clk);
            if (bus8.done) begin
                if (n < 3) begin res_seen[n] = bus8.result; at_seen[n] = i; end
                n++;
            end
            if (i < 30) begin
                bus8.start = 1'b1; bus8.op_sub = 1'b0;
                bus8.a = 8'(i * 3 + 1); bus8.b = 8'(i * 5 + 2);
            end else begin
                bus8.start = 1'b0;
            end
        end
        tests++;
        if (n !== 3) begin
            fails++; $display("FAIL b2b_done_count got=%0d want 3", n);
        end
        for (int k = 0; k < 3 && k < n; k++) begin
            tests++;
            if (res_seen[k] !== exp_res[k] || at_seen[k] !== 9 + 10 * k) begin
                fails++; $display("FAIL b2b_op%0d result=%h at=%0d want %h at %0d", k, res_seen[k], at_seen[k], exp_res[k], 9 + 10 * k);
            end
        end
    endtask

    task automatic test_reset_mid;
        int cyc, bsy;
        @(negedge clk);
        bus8.start = 1'b1; bus8.op_sub = 1'b0; bus8.a = 8'h0F; bus8.b = 8'h01;
        @(negedge clk);
        bus8.start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests++;
        if ({bus8.busy, bus8.done, bus8.result, bus8.cout, bus8.overflow, bus8.zero} !== 13'h0) begin
            fails++; $display("FAIL mid_reset busy=%b done=%b result=%h c/v/z=%b%b%b want all 0", bus8.busy, bus8.done, bus8.result, bus8.cout, bus8.overflow, bus8.zero);
        end
        repeat (10) @(negedge clk);
        tests++;
        if (bus8.done !== 1'b0 || bus8.busy !== 1'b0) begin
            fails++; $display("FAIL mid_reset_discard done=%b busy=%b want 0 0", bus8.done, bus8.busy);
        end
        do_op8(1'b0, 8'h0F, 8'h01, cyc, bsy);
        tests++;
        if (cyc !== 9 || {bus8.result, bus8.cout, bus8.overflow, bus8.zero} !== {8'h10, 3'b000}) begin
            fails++; $display("FAIL mid_reset_fresh cyc=%0d result=%h c/v/z=%b%b%b want 9 10 000", cyc, bus8.result, bus8.cout, bus8.overflow, bus8.zero);
        end
    endtask

    task automatic test_random_w2;
        logic [1:0]  a, b;
        logic        sub;
        logic [66:0] e;
        int          cyc;
        for (int n = 0; n < 1000; n++) begin
            a = 2'($urandom); b = 2'($urandom); sub = 1'($urandom);
            e = model(2, sub, {62'h0, a}, {62'h0, b});
            @(negedge clk);
            bus2.start = 1'b1; bus2.op_sub = sub; bus2.a = a; bus2.b = b;
            @(negedge clk);
            bus2.start = 1'b0; bus2.a = ~a; bus2.op_sub = ~sub;
            cyc = 1;
            while (!bus2.done && cyc < 20) begin @(negedge clk); cyc++; end
            tests++;
            if (cyc !== 3 || {bus2.result, bus2.cout, bus2.overflow, bus2.zero} !== {e[4:3], e[2:0]}) begin
                fails++; $display("FAIL w2_op%0d sub=%b a=%h b=%h cyc=%0d result=%h cvz=%b%b%b want 3 %h %b", n, sub, a, b, cyc, bus2.result, bus2.cout, bus2.overflow, bus2.zero, e[4:3], e[2:0]);
            end
        end
    endtask

    task automatic test_random_w32;
        logic [31:0] a, b;
        logic        sub;
        logic [66:0] e;
        int          cyc;
        for (int n = 0; n < 1000; n++) begin
            a = $urandom; b = $urandom; sub = 1'($urandom);
            if (n < 4) begin a = (n[0]) ? 32'h8000_0000 : 32'hFFFF_FFFF; b = (n[1]) ? a : 32'h1; end
            e = model(32, sub, {32'h0, a}, {32'h0, b});
            @(negedge clk);
            bus32.start = 1'b1; bus32.op_sub = sub; bus32.a = a; bus32.b = b;
            @(negedge clk);
            bus32.start = 1'b0; bus32.b = ~b; bus32.op_sub = ~sub;
            cyc = 1;
            while (!bus32.done && cyc < 60) begin @(negedge clk); cyc++; end
            tests++;
            if (cyc !== 33 || {bus32.result, bus32.cout, bus32.overflow, bus32.zero} !== {e[34:3], e[2:0]}) begin
                fails++; $display("FAIL w32_op%0d sub=%b a=%h b=%h cyc=%0d result=%h cvz=%b%b%b want 33 %h %b", n, sub, a, b, cyc, bus32.result, bus32.cout, bus32.overflow, bus32.zero, e[34:3], e[2:0]);
            end
        end
    endtask

    initial begin
        bus8.start = 1'b0;  bus8.op_sub = 1'b0;  bus8.a = '0;  bus8.b = '0;
        bus2.start = 1'b0;  bus2.op_sub = 1'b0;  bus2.a = '0;  bus2.b = '0;
        bus32.start = 1'b0; bus32.op_sub = 1'b0; bus32.a = '0; bus32.b = '0;
        test_reset;
        test_add;
        test_sub;
        test_back_to_back;
        test_reset_mid;
        test_random_w2;
        test_random_w32;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
